seg_display_capture: RTL and testbench
======================================

# seg_display_capture

Read-back monitor for the four-digit multiplexed seven-segment display bus. It sits on the same `anode_vec`/`cathode_vec` nets the stopwatch drives and samples them on the system clock. It waits for each lit digit to settle, decodes the segment pattern back to a hex value, and publishes a coherent four-digit frame once every digit position has been seen. It is used on-board for self-check and in simulation as the display-side checker.

## Interface
- `SETTLE`, default 4: consecutive identical samples required before a digit is accepted (range 1–15).
- `TIMEOUT`, default 262144: cycles allowed to collect a full frame before it is abandoned (counter width 18).
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `anode_vec` in 4: digit enables, active-low; bit *i* low means digit *i* is lit.
- `cathode_vec` in 7: segments, active-low, bit order {g,f,e,d,c,b,a}.
- `digits` out 16: last committed frame; digit *i* in bits [4i+3:4i].
- `blank` out 4: per digit, the committed pattern was all-off (7'h7F).
- `seg_err` out 4: per digit, the committed pattern was neither a hex glyph nor blank.
- `frame_valid` out 1: one-cycle pulse when `digits`/`blank`/`seg_err` update.
- `scan_err` out 1: one-cycle pulse when more than one anode is low in a sample.
- `timeout` out 1: one-cycle pulse when a frame is abandoned.

## Operation
- Inputs are registered once (`a_q`, `c_q`); all decisions use the registered copy.
- FSM states:
  - IDLE: no anode low.
  - SETTLE: one anode low, counting.
  - HOLD: digit captured, waiting for the bus to change.
- From any state:
  - `a_q` = 4'hF goes to IDLE.
  - `a_q` with ≥2 zeros pulses `scan_err` and goes to IDLE; nothing is captured.
  - `a_q` one-hot-low goes to SETTLE with count 1 if `{a_q,c_q}` differs from the previous sample.
- In SETTLE, an unchanged sample increments the count. When count reaches `SETTLE`, the digit is captured into the staging slot for that anode, its bit is set in `seen_mask`, and the FSM goes to HOLD.
- In HOLD, unchanged samples have no effect. A change is handled by the any-state rules above.
- Decode table, kept in the package (active-low, hex): 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E.
  - 7F gives value 0 with blank=1.
  - Any other pattern gives value 0 with seg_err=1.
- Recapturing a digit already in `seen_mask` overwrites its staging slot (latest wins).
- When `seen_mask` becomes 4'hF:
  - The next cycle copies staging to the outputs, pulses `frame_valid` and clears `seen_mask`.
  - If a capture happens on that same cycle, it goes into the new frame's mask.
- Frame timer:
  - Counts every cycle while `seen_mask` ≠ 0.
  - Clears on commit.
  - At `TIMEOUT`−1 without commit, it pulses `timeout`, clears `seen_mask` and the timer, and leaves the outputs unchanged.

## Timing
- Reset values:
  - `digits` = 16'h0000, `blank` = 4'hF, `seg_err` = 4'h0.
  - All pulses 0, FSM in IDLE, `seen_mask` = 0, timer 0, `a_q` = 4'hF, `c_q` = 7'h7F.
- Capture latency: the digit is captured `SETTLE`+1 cycles after the first stable input cycle (1 register stage plus `SETTLE` samples).
- Commit latency: `frame_valid` is asserted 1 cycle after the capture that completes the mask.
- `scan_err` asserts 1 cycle after the offending input.
- Reset mid-frame discards staging and mask; no pulse is emitted.
- A glitch shorter than `SETTLE` cycles is never captured and restarts the count.

## Structure
- Package `seg_pkg`:
  - Glyph constants `SEG_0`…`SEG_F` and `SEG_BLANK`.
  - `seg_decode` function returning {err, blank, value[3:0]}.
  - Digit-count constant `NUM_DIGITS` = 4.
- Sub-module `seg_glyph_decoder`: purely combinational 7→6 decode, instantiated once on `c_q`.
- Everything else (FSM, settle counter, mask, staging, timer) is in the top module.

## Test plan
- Drive digits 3,2,1,0 with glyphs for 1,2,3,4, each for 10 cycles with 2 blank cycles between, `SETTLE`=4. Required: one `frame_valid`, `digits` = 16'h1234, `blank` = 0, `seg_err` = 0.
- Hold digit 0 with 7'h40 for 3 cycles, then 7'h79 for 10 cycles. Required: the staged value is 1, never 0.
- Drive `anode_vec` = 4'b0011 for 1 cycle. Required: one `scan_err` pulse 1 cycle later; `seen_mask` is unchanged.
- Light only digits 0–2, `TIMEOUT`=64. Required: `timeout` pulse at cycle 63 after the first capture; `digits` keep their previous value.
- Drive digit 2 with 7'h7F and digit 1 with 7'h55, others valid. Required: `blank` = 4'b0100, `seg_err` = 4'b0010 at `frame_valid`.
- Assert `rst` for 1 cycle after 3 captures. Required: all outputs at reset values, and the next full scan commits normally.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display read-back monitor.
// Holds the active-low glyph table, the decoded-digit record, FSM state
// encoding and small helpers used by seg_glyph_decoder and
// seg_display_capture.
//   seg_decode(cathode) -> {err, blank, value[3:0]}
//   low_index(anode)    -> index of the (single) low anode bit
package seg_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int TIMER_W    = 18;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } cap_state_e;

    typedef struct packed {
        logic       err;
        logic       blank;
        logic [3:0] value;
    } seg_dec_t;

    // Value a staging slot holds before anything has been captured into it.
    localparam seg_dec_t DEC_EMPTY = '{err: 1'b0, blank: 1'b1, value: 4'h0};

    // Unknown patterns report value 0 with err set; all-off reports blank.
    function automatic seg_dec_t seg_decode(input logic [6:0] cathode);
        seg_dec_t r;
        r = '0;
        case (cathode)
            SEG_0:     r.value = 4'h0;
            SEG_1:     r.value = 4'h1;
            SEG_2:     r.value = 4'h2;
            SEG_3:     r.value = 4'h3;
            SEG_4:     r.value = 4'h4;
            SEG_5:     r.value = 4'h5;
            SEG_6:     r.value = 4'h6;
            SEG_7:     r.value = 4'h7;
            SEG_8:     r.value = 4'h8;
            SEG_9:     r.value = 4'h9;
            SEG_A:     r.value = 4'hA;
            SEG_B:     r.value = 4'hB;
            SEG_C:     r.value = 4'hC;
            SEG_D:     r.value = 4'hD;
            SEG_E:     r.value = 4'hE;
            SEG_F:     r.value = 4'hF;
            SEG_BLANK: r.blank = 1'b1;
            default:   r.err   = 1'b1;
        endcase
        return r;
    endfunction

    // Only meaningful when exactly one anode is low.
    function automatic logic [1:0] low_index(input logic [NUM_DIGITS-1:0] anode);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!anode[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_glyph_decoder.sv
// Combinational decode of an active-low seven-segment pattern.
//   cathode : segment pattern {g,f,e,d,c,b,a}, active-low
//   decoded : {err, blank, value[3:0]}
module seg_glyph_decoder
    import seg_pkg::*;
(
    input  logic [6:0] cathode,
    output seg_dec_t   decoded
);

    assign decoded = seg_decode(cathode);

endmodule

// File: rtl/seg_display_capture.sv
// Read-back monitor for the multiplexed four-digit seven-segment bus.
// Samples anode/cathode, waits for each lit digit to be stable for SETTLE
// samples, decodes it into a staging slot and publishes a coherent frame
// once all four digit positions have been seen.
//   clk, rst     : system clock, synchronous active-high reset
//   anode_vec    : digit enables, active-low
//   cathode_vec  : segments, active-low {g,f,e,d,c,b,a}
//   digits       : last committed frame, digit i in [4i+3:4i]
//   blank        : per digit, committed pattern was all-off
//   seg_err      : per digit, committed pattern was not a valid glyph
//   frame_valid  : pulse when digits/blank/seg_err update
//   scan_err     : pulse while the sampled anodes have more than one low bit
//   timeout      : pulse when an incomplete frame is abandoned
module seg_display_capture
    import seg_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 262144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  anode_vec,
    input  logic [6:0]  cathode_vec,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [3:0]  seg_err,
    output logic        frame_valid,
    output logic        scan_err,
    output logic        timeout
);

    localparam logic [3:0]         SETTLE_CNT = 4'(SETTLE);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    logic [3:0]            a_q, a_d, prev_a_q, prev_a_d;
    logic [6:0]            c_q, c_d, prev_c_q, prev_c_d;
    cap_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  capture;
    logic                  multi_low;
    logic                  sample_changed;
    logic [1:0]            cap_idx;
    seg_dec_t              decoded;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    seg_dec_t              stage_q [NUM_DIGITS];
    seg_dec_t              stage_d [NUM_DIGITS];
    logic [15:0]           digits_q, digits_d;
    logic [3:0]            blank_q, blank_d;
    logic [3:0]            seg_err_q, seg_err_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  commit;
    logic                  timeout_hit;

    seg_glyph_decoder u_decoder (
        .cathode (c_q),
        .decoded (decoded)
    );

    assign cap_idx = low_index(a_q);

    // One register stage on the bus, plus a copy of the previous sample so
    // that "bus changed" can be judged purely on registered values.
    always_comb begin
        a_d      = anode_vec;
        c_d      = cathode_vec;
        prev_a_d = a_q;
        prev_c_d = c_q;
    end

    // FSM state register and settle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. A change on a single lit digit restarts the settle
    // count at 1; the capture fires on the sample that brings the count to
    // SETTLE, so SETTLE=1 captures on the very first sample of a new digit.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        capture        = 1'b0;
        multi_low      = 1'b0;
        sample_changed = ({a_q, c_q} != {prev_a_q, prev_c_q});
        if (a_q == 4'hF) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if ($countones(~a_q) > 1) begin
            multi_low = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = '0;
        end else if (sample_changed) begin
            state_d = ST_SETTLE;
            cnt_d   = 4'd1;
        end else if (state_q == ST_SETTLE) begin
            cnt_d = cnt_q + 4'd1;
        end
        if ((state_d == ST_SETTLE) && (cnt_d == SETTLE_CNT)) begin
            capture = 1'b1;
            state_d = ST_HOLD;
        end
    end

    // Output and frame logic. Commit and timeout both act on the mask as it
    // stood before this cycle, so a capture landing on the same cycle is
    // kept as the first digit of the next frame.
    always_comb begin
        commit      = (mask_q == '1);
        timeout_hit = (mask_q != '0) && !commit && (timer_q == TIMER_LAST);
        mask_d      = (commit || timeout_hit) ? '0 : mask_q;
        timer_d     = '0;
        if (!commit && !timeout_hit && (mask_q != '0)) begin
            timer_d = timer_q + TIMER_W'(1);
        end
        stage_d = stage_q;
        if (capture) begin
            stage_d[cap_idx] = decoded;
            mask_d[cap_idx]  = 1'b1;
        end
        digits_d      = digits_q;
        blank_d       = blank_q;
        seg_err_d     = seg_err_q;
        frame_valid_d = commit;
        if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits_d[4*i +: 4] = stage_q[i].value;
                blank_d[i]         = stage_q[i].blank;
                seg_err_d[i]       = stage_q[i].err;
            end
        end
    end

    // Datapath registers: bus samples, staging slots, mask, timer, outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q           <= 4'hF;
            c_q           <= SEG_BLANK;
            prev_a_q      <= 4'hF;
            prev_c_q      <= SEG_BLANK;
            mask_q        <= '0;
            timer_q       <= '0;
            digits_q      <= 16'h0000;
            blank_q       <= 4'hF;
            seg_err_q     <= 4'h0;
            frame_valid_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                stage_q[i] <= DEC_EMPTY;
            end
        end else begin
            a_q           <= a_d;
            c_q           <= c_d;
            prev_a_q      <= prev_a_d;
            prev_c_q      <= prev_c_d;
            mask_q        <= mask_d;
            timer_q       <= timer_d;
            digits_q      <= digits_d;
            blank_q       <= blank_d;
            seg_err_q     <= seg_err_d;
            frame_valid_q <= frame_valid_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign digits      = digits_q;
    assign blank       = blank_q;
    assign seg_err     = seg_err_q;
    assign frame_valid = frame_valid_q;
    assign scan_err    = multi_low;
    assign timeout     = timeout_hit;

endmodule

// File: tb/tb_seg_display_capture.sv
// Self-checking bench for seg_display_capture. Directed scenarios followed
// by a randomized scan, every cycle compared against a behavioural model
// that reasons about run lengths of identical input samples.
module tb_seg_display_capture;

    localparam int SETTLE_P  = 4;
    localparam int TIMEOUT_P = 64;

    logic        clk;
    logic        rst;
    logic [3:0]  anode_vec;
    logic [6:0]  cathode_vec;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  seg_err;
    logic        frame_valid;
    logic        scan_err;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int fv_count = 0;
    int scan_count = 0;
    int tmo_count = 0;
    int tmo_first = -1;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [10:0] m_prev_in;
    int          m_run;
    bit          m_pend;
    int          m_pend_idx;
    int          m_pend_val;
    bit          m_pend_blank;
    bit          m_pend_err;
    int          m_mask;
    int          m_timer;
    int          m_stage_val [4];
    bit          m_stage_blank [4];
    bit          m_stage_err [4];
    logic [15:0] m_digits;
    logic [3:0]  m_blank;
    logic [3:0]  m_err;
    bit          m_fv;
    bit          m_scan;
    bit          m_tmo;

    seg_display_capture #(
        .SETTLE  (SETTLE_P),
        .TIMEOUT (TIMEOUT_P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .anode_vec   (anode_vec),
        .cathode_vec (cathode_vec),
        .digits      (digits),
        .blank       (blank),
        .seg_err     (seg_err),
        .frame_valid (frame_valid),
        .scan_err    (scan_err),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    function automatic int zeroCount(input logic [3:0] a);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (!a[i]) n++;
        end
        return n;
    endfunction

    function automatic logic [3:0] anodeFor(input int idx);
        logic [3:0] a;
        a = 4'hF;
        a[idx] = 1'b0;
        return a;
    endfunction

    task automatic tbDecode(input logic [6:0] c, output int val, output bit bl, output bit er);
        val = 0;
        bl  = 1'b0;
        er  = 1'b1;
        if (c == 7'h7F) begin
            bl = 1'b1;
            er = 1'b0;
        end else begin
            for (int v = 0; v < 16; v++) begin
                if (glyph_tab[v] == c) begin
                    val = v;
                    er  = 1'b0;
                end
            end
        end
    endtask

    task automatic modelReset();
        m_prev_in = {4'hF, 7'h7F};
        m_run     = 0;
        m_pend    = 1'b0;
        m_mask    = 0;
        m_timer   = 0;
        for (int i = 0; i < 4; i++) begin
            m_stage_val[i]   = 0;
            m_stage_blank[i] = 1'b1;
            m_stage_err[i]   = 1'b0;
        end
        m_digits = 16'h0000;
        m_blank  = 4'hF;
        m_err    = 4'h0;
        m_fv     = 1'b0;
        m_scan   = 1'b0;
        m_tmo    = 1'b0;
    endtask

    // A digit is taken once its exact pattern has been seen SETTLE times in a
    // row; the result becomes visible one cycle after that sample is seen.
    task automatic modelEdge(input logic [3:0] a, input logic [6:0] c);
        bit commit;
        bit abandon;
        commit  = (m_mask == 15);
        abandon = (m_mask != 0) && !commit && (m_timer == TIMEOUT_P - 1);
        m_fv    = commit;
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                m_digits[4*i +: 4] = 4'(m_stage_val[i]);
                m_blank[i]         = m_stage_blank[i];
                m_err[i]           = m_stage_err[i];
            end
            m_mask  = 0;
            m_timer = 0;
        end else if (abandon) begin
            m_mask  = 0;
            m_timer = 0;
        end else if (m_mask != 0) begin
            m_timer++;
        end
        if (m_pend) begin
            m_stage_val[m_pend_idx]   = m_pend_val;
            m_stage_blank[m_pend_idx] = m_pend_blank;
            m_stage_err[m_pend_idx]   = m_pend_err;
            m_mask = m_mask | (1 << m_pend_idx);
            m_pend = 1'b0;
        end
        if ({a, c} == m_prev_in) m_run++;
        else m_run = 1;
        m_prev_in = {a, c};
        m_scan = (zeroCount(a) >= 2);
        if (zeroCount(a) == 1 && m_run == SETTLE_P) begin
            m_pend = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (!a[i]) m_pend_idx = i;
            end
            tbDecode(c, m_pend_val, m_pend_blank, m_pend_err);
        end
        m_tmo = (m_mask != 0) && (m_mask != 15) && (m_timer == TIMEOUT_P - 1);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic checkModel();
        checkOutput("digits", digits, m_digits);
        checkOutput("blank", 16'(blank), 16'(m_blank));
        checkOutput("seg_err", 16'(seg_err), 16'(m_err));
        checkOutput("frame_valid", 16'(frame_valid), 16'(m_fv));
        checkOutput("scan_err", 16'(scan_err), 16'(m_scan));
        checkOutput("timeout", 16'(timeout), 16'(m_tmo));
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [6:0] c, input int n);
        for (int k = 0; k < n; k++) begin
            anode_vec   = a;
            cathode_vec = c;
            @(posedge clk);
            if (rst) modelReset();
            else modelEdge(a, c);
            @(negedge clk);
            cycle++;
            if (frame_valid) fv_count++;
            if (scan_err) scan_count++;
            if (timeout) begin
                tmo_count++;
                if (tmo_first < 0) tmo_first = cycle;
            end
            checkModel();
        end
    endtask

    task automatic showDigit(input int idx, input int val, input int dwell);
        applyStimulus(anodeFor(idx), glyph_tab[val], dwell);
        applyStimulus(4'hF, 7'h7F, 2);
    endtask

    initial begin
        int base;
        int r;
        logic [3:0] ra;
        logic [6:0] rc;
        clk         = 1'b0;
        rst         = 1'b1;
        anode_vec   = 4'hF;
        cathode_vec = 7'h7F;
        modelReset();

        applyStimulus(4'hF, 7'h7F, 2);
        rst = 1'b0;
        checkOutput("reset_digits", digits, 16'h0000);
        checkOutput("reset_blank", 16'(blank), 16'h000F);
        checkOutput("reset_seg_err", 16'(seg_err), 16'h0000);
        checkOutput("reset_pulses", 16'({frame_valid, scan_err, timeout}), 16'h0000);

        $display("[TB] frame 1234");
        fv_count = 0;
        showDigit(3, 1, 10);
        showDigit(2, 2, 10);
        showDigit(1, 3, 10);
        showDigit(0, 4, 10);
        applyStimulus(4'hF, 7'h7F, 3);
        checkOutput("f1234_count", 16'(fv_count), 16'd1);
        checkOutput("f1234_digits", digits, 16'h1234);
        checkOutput("f1234_blank", 16'(blank), 16'h0000);
        checkOutput("f1234_err", 16'(seg_err), 16'h0000);

        $display("[TB] short glitch before stable digit");
        fv_count = 0;
        showDigit(3, 5, 10);
        showDigit(2, 6, 10);
        showDigit(1, 7, 10);
        applyStimulus(anodeFor(0), 7'h40, 3);
        applyStimulus(anodeFor(0), 7'h79, 10);
        applyStimulus(4'hF, 7'h7F, 4);
        checkOutput("glitch_count", 16'(fv_count), 16'd1);
        checkOutput("glitch_digits", digits, 16'h5671);

        $display("[TB] scan error mid-frame");
        fv_count   = 0;
        scan_count = 0;
        showDigit(3, 8, 10);
        showDigit(2, 9, 10);
        applyStimulus(4'b0011, 7'h40, 1);
        checkOutput("scan_pulse", 16'(scan_err), 16'd1);
        applyStimulus(4'hF, 7'h7F, 1);
        checkOutput("scan_once", 16'(scan_count), 16'd1);
        showDigit(1, 10, 10);
        showDigit(0, 11, 10);
        applyStimulus(4'hF, 7'h7F, 3);
        checkOutput("scan_count_fv", 16'(fv_count), 16'd1);
        checkOutput("scan_digits", digits, 16'h89AB);

        $display("[TB] timeout with three digits lit");
        fv_count  = 0;
        tmo_count = 0;
        tmo_first = -1;
        base      = cycle;
        for (int rnd = 0; rnd < 3; rnd++) begin
            showDigit(0, 12, 10);
            showDigit(1, 13, 10);
            showDigit(2, 14, 10);
        end
        checkOutput("tmo_count", 16'(tmo_count), 16'd1);
        checkOutput("tmo_cycle", 16'(tmo_first - base), 16'(SETTLE_P + TIMEOUT_P));
        checkOutput("tmo_no_frame", 16'(fv_count), 16'd0);
        checkOutput("tmo_digits", digits, 16'h89AB);
        applyStimulus(4'hF, 7'h7F, 70);

        $display("[TB] blank and bad pattern");
        fv_count = 0;
        showDigit(3, 15, 10);
        applyStimulus(anodeFor(2), 7'h7F, 10);
        applyStimulus(4'hF, 7'h7F, 2);
        applyStimulus(anodeFor(1), 7'h55, 10);
        applyStimulus(4'hF, 7'h7F, 2);
        showDigit(0, 0, 10);
        applyStimulus(4'hF, 7'h7F, 3);
        checkOutput("bl_count", 16'(fv_count), 16'd1);
        checkOutput("bl_blank", 16'(blank), 16'h0004);
        checkOutput("bl_err", 16'(seg_err), 16'h0002);
        checkOutput("bl_digits", digits, 16'hF000);

        $display("[TB] reset mid-frame");
        showDigit(3, 1, 10);
        showDigit(2, 2, 10);
        showDigit(1, 3, 10);
        rst = 1'b1;
        applyStimulus(4'hF, 7'h7F, 1);
        rst = 1'b0;
        checkOutput("mrst_digits", digits, 16'h0000);
        checkOutput("mrst_blank", 16'(blank), 16'h000F);
        checkOutput("mrst_err", 16'(seg_err), 16'h0000);
        checkOutput("mrst_pulses", 16'({frame_valid, scan_err, timeout}), 16'h0000);
        fv_count = 0;
        showDigit(3, 4, 10);
        showDigit(2, 3, 10);
        showDigit(1, 2, 10);
        showDigit(0, 1, 10);
        applyStimulus(4'hF, 7'h7F, 3);
        checkOutput("mrst_count", 16'(fv_count), 16'd1);
        checkOutput("mrst_digits2", digits, 16'h4321);

        $display("[TB] randomized scan");
        for (int s = 0; s < 300; s++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                ra = 4'($urandom_range(0, 15));
                if (zeroCount(ra) < 2) ra = ra & 4'b1100;
                applyStimulus(ra, glyph_tab[$urandom_range(0, 15)], $urandom_range(1, 2));
            end else if (r == 1) begin
                applyStimulus(4'hF, 7'h7F, $urandom_range(1, 3));
            end else begin
                r = $urandom_range(0, 9);
                if (r == 0) rc = 7'h7F;
                else if (r == 1) rc = 7'($urandom_range(0, 127));
                else rc = glyph_tab[$urandom_range(0, 15)];
                applyStimulus(anodeFor($urandom_range(0, 3)), rc, $urandom_range(1, 8));
            end
        end
        applyStimulus(4'hF, 7'h7F, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
